// File: rtl/calc2_pkg.sv
// Shared types for the calc2 request issuer: command/response encodings,
// tag type, issue-FSM states and a lowest-free-tag picker.
package calc2_pkg;

   localparam int NUM_TAGS = 4;

   typedef logic [1:0] tag_t;

   typedef enum logic [3:0] {
      CMD_NOP = 4'd0,
      CMD_ADD = 4'd1,
      CMD_SUB = 4'd2,
      CMD_SHL = 4'd5,
      CMD_SHR = 4'd6
   } cmd_e;

   typedef enum logic [1:0] {
      RESP_NONE    = 2'd0,
      RESP_OK      = 2'd1,
      RESP_ERR     = 2'd2,
      RESP_TIMEOUT = 2'd3
   } resp_e;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SEND_A = 2'd1,
      ST_SEND_B = 2'd2
   } state_e;

   function automatic tag_t lowest_free(input logic [NUM_TAGS-1:0] free);
      tag_t t = '0;
      for (int i = NUM_TAGS - 1; i >= 0; i--) begin
         if (free[i]) t = tag_t'(i);
      end
      return t;
   endfunction

endpackage

// File: rtl/calc2_tag_rob.sv
// Tag bookkeeping for the issuer: free/quarantine masks, 4-entry order queue,
// per-tag result slots and in-order retirement of completions.
module calc2_tag_rob
   import calc2_pkg::*;
(
   input  logic        c_clk,
   input  logic        reset,
   input  logic        i_push,
   input  logic        i_timeout,
   input  logic        i_cpl_ready,
   input  logic [1:0]  i_calc_resp,
   input  logic [31:0] i_calc_data,
   input  logic [1:0]  i_calc_tag,
   output logic [1:0]  o_alloc_tag,
   output logic        o_can_alloc,
   output logic [2:0]  o_count,
   output logic        o_cpl_valid,
   output logic [1:0]  o_cpl_resp,
   output logic [31:0] o_cpl_data,
   output logic [1:0]  o_cpl_tag,
   output logic        o_spurious
);

   logic [NUM_TAGS-1:0] r_busy, r_done, r_quar;
   logic [1:0]          r_resp [NUM_TAGS];
   logic [31:0]         r_data [NUM_TAGS];
   tag_t                r_q    [NUM_TAGS];
   logic [1:0]          r_head, r_tail;
   logic [2:0]          r_count;
   logic                r_spurious;

   tag_t                w_head_tag;
   logic [NUM_TAGS-1:0] w_free;
   logic                w_hit, w_cap, w_late, w_spur, w_to, w_pop;

   assign w_head_tag  = r_q[r_head];
   assign w_free      = ~(r_busy | r_quar);
   assign o_can_alloc = |w_free;
   assign o_alloc_tag = lowest_free(w_free);
   assign o_count     = r_count;
   assign o_spurious  = r_spurious;

   assign o_cpl_valid = (r_count != 3'd0) && r_done[w_head_tag];
   assign o_cpl_resp  = o_cpl_valid ? r_resp[w_head_tag] : 2'd0;
   assign o_cpl_data  = o_cpl_valid ? r_data[w_head_tag] : 32'd0;
   assign o_cpl_tag   = o_cpl_valid ? w_head_tag : 2'd0;
   assign w_pop       = o_cpl_valid && i_cpl_ready;

   // A quarantined tag's late answer is swallowed; anything else not awaiting a response is spurious.
   assign w_hit  = (i_calc_resp != RESP_NONE);
   assign w_late = w_hit && r_quar[i_calc_tag];
   assign w_cap  = w_hit && !r_quar[i_calc_tag] && r_busy[i_calc_tag] && !r_done[i_calc_tag];
   assign w_spur = w_hit && !w_late && !w_cap;
   assign w_to   = i_timeout && (r_count != 3'd0) && !r_done[w_head_tag] &&
                   !(w_cap && (i_calc_tag == w_head_tag));

   always_ff @(posedge c_clk) begin
      // NOTE: result slots and queue storage are deliberately left out of reset;
      // they are only read behind the busy/done/count flags, which are reset.
      if (reset) begin
         r_busy     <= '0;
         r_done     <= '0;
         r_quar     <= '0;
         r_head     <= '0;
         r_tail     <= '0;
         r_count    <= '0;
         r_spurious <= 1'b0;
      end else begin
         if (w_cap) begin
            r_done[i_calc_tag] <= 1'b1;
            r_resp[i_calc_tag] <= i_calc_resp;
            r_data[i_calc_tag] <= (i_calc_resp == RESP_OK) ? i_calc_data : 32'd0;
         end
         if (w_late) r_quar[i_calc_tag] <= 1'b0;
         if (w_spur) r_spurious <= 1'b1;
         if (w_to) begin
            r_done[w_head_tag] <= 1'b1;
            r_resp[w_head_tag] <= RESP_TIMEOUT;
            r_data[w_head_tag] <= 32'd0;
            r_quar[w_head_tag] <= 1'b1;
         end
         if (w_pop) begin
            r_busy[w_head_tag] <= 1'b0;
            r_done[w_head_tag] <= 1'b0;
            r_head             <= r_head + 2'd1;
         end
         if (i_push) begin
            r_busy[o_alloc_tag] <= 1'b1;
            r_done[o_alloc_tag] <= 1'b0;
            r_q[r_tail]         <= o_alloc_tag;
            r_tail              <= r_tail + 2'd1;
         end
         r_count <= r_count + {2'b00, i_push} - {2'b00, w_pop};
      end
   end

endmodule

// File: rtl/calc2_req_issuer.sv
// Upstream driver for one calc2 request port: issue FSM plus tag ROB.
// Optional watchdog on the oldest op is enabled by CALC2_ISSUER_TIMEOUT_EN.
module calc2_req_issuer
   import calc2_pkg::*;
#(
   parameter int MAX_OUTSTANDING = 4,
   parameter int TIMEOUT_CYCLES  = 255
) (
   input  logic        c_clk,
   input  logic        reset,
   input  logic        op_valid,
   output logic        op_ready,
   input  logic [3:0]  op_cmd,
   input  logic [31:0] op_a,
   input  logic [31:0] op_b,
   output logic [3:0]  req_cmd_out,
   output logic [31:0] req_data_out,
   output logic [1:0]  req_tag_out,
   input  logic [1:0]  calc_resp,
   input  logic [31:0] calc_data,
   input  logic [1:0]  calc_tag,
   output logic        cpl_valid,
   input  logic        cpl_ready,
   output logic [1:0]  cpl_resp,
   output logic [31:0] cpl_data,
   output logic [1:0]  cpl_tag,
   output logic        spurious_err
);

   localparam logic [2:0] MAX_OUT = 3'(MAX_OUTSTANDING);

   state_e      r_state, w_state_nxt;
   logic [3:0]  r_cmd;
   logic [31:0] r_a, r_b;
   tag_t        r_tag;

   logic [1:0]  w_alloc_tag;
   logic        w_can_alloc, w_accept, w_timeout;
   logic [2:0]  w_count;

   assign op_ready = (r_state != ST_SEND_A) && (w_count < MAX_OUT) && w_can_alloc;
   assign w_accept = op_valid && op_ready;

   always_ff @(posedge c_clk) begin
      if (reset) begin
         r_state <= ST_IDLE;
         r_cmd   <= '0;
         r_a     <= '0;
         r_b     <= '0;
         r_tag   <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_accept) begin
            r_cmd <= op_cmd;
            r_a   <= op_a;
            r_b   <= op_b;
            r_tag <= w_alloc_tag;
         end
      end
   end

   always_comb begin
      // NOTE: every output of this block is defaulted first so no path infers a latch.
      w_state_nxt  = r_state;
      req_cmd_out  = CMD_NOP;
      req_data_out = '0;
      req_tag_out  = '0;
      unique case (r_state)
         ST_IDLE:   if (w_accept) w_state_nxt = ST_SEND_A;
         ST_SEND_A: begin
            req_cmd_out  = r_cmd;
            req_data_out = r_a;
            req_tag_out  = r_tag;
            w_state_nxt  = ST_SEND_B;
         end
         ST_SEND_B: begin
            req_data_out = r_b;
            req_tag_out  = r_tag;
            w_state_nxt  = w_accept ? ST_SEND_A : ST_IDLE;
         end
         default:   w_state_nxt = ST_IDLE;
      endcase
   end

`ifdef CALC2_ISSUER_TIMEOUT_EN
   localparam logic [15:0] WD_LIMIT = 16'(TIMEOUT_CYCLES);
   logic [15:0] r_wd_cnt;
   logic        w_head_pending;

   // Head waiting on calc2; the count restarts whenever the head retires or resolves.
   assign w_head_pending = (w_count != 3'd0) && !cpl_valid;
   assign w_timeout      = w_head_pending && (r_wd_cnt == WD_LIMIT);

   always_ff @(posedge c_clk) begin
      if (reset || !w_head_pending) r_wd_cnt <= '0;
      else if (!w_timeout)          r_wd_cnt <= r_wd_cnt + 16'd1;
   end
`else
   // Watchdog absent: the limit can never be hit.
   assign w_timeout = (TIMEOUT_CYCLES < 0);
`endif

   calc2_tag_rob u_rob (
      .c_clk       (c_clk),
      .reset       (reset),
      .i_push      (w_accept),
      .i_timeout   (w_timeout),
      .i_cpl_ready (cpl_ready),
      .i_calc_resp (calc_resp),
      .i_calc_data (calc_data),
      .i_calc_tag  (calc_tag),
      .o_alloc_tag (w_alloc_tag),
      .o_can_alloc (w_can_alloc),
      .o_count     (w_count),
      .o_cpl_valid (cpl_valid),
      .o_cpl_resp  (cpl_resp),
      .o_cpl_data  (cpl_data),
      .o_cpl_tag   (cpl_tag),
      .o_spurious  (spurious_err)
   );

endmodule

// File: tb/tb_calc2_req_issuer.sv
// Directed bench for calc2_req_issuer: stimulus pushes expected completions into a
// scoreboard queue, a negedge monitor pops and compares on each completion handshake.
module tb_calc2_req_issuer;

   logic        c_clk = 1'b0;
   logic        reset;
   logic        op_valid;
   logic        op_ready;
   logic [3:0]  op_cmd;
   logic [31:0] op_a, op_b;
   logic [3:0]  req_cmd_out;
   logic [31:0] req_data_out;
   logic [1:0]  req_tag_out;
   logic [1:0]  calc_resp;
   logic [31:0] calc_data;
   logic [1:0]  calc_tag;
   logic        cpl_valid;
   logic        cpl_ready;
   logic [1:0]  cpl_resp;
   logic [31:0] cpl_data;
   logic [1:0]  cpl_tag;
   logic        spurious_err;

   typedef struct {
      logic [1:0]  resp;
      logic [31:0] data;
      logic [1:0]  tag;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_pass   = 0;

   calc2_req_issuer #(.MAX_OUTSTANDING(4), .TIMEOUT_CYCLES(8)) dut (
      .c_clk        (c_clk),
      .reset        (reset),
      .op_valid     (op_valid),
      .op_ready     (op_ready),
      .op_cmd       (op_cmd),
      .op_a         (op_a),
      .op_b         (op_b),
      .req_cmd_out  (req_cmd_out),
      .req_data_out (req_data_out),
      .req_tag_out  (req_tag_out),
      .calc_resp    (calc_resp),
      .calc_data    (calc_data),
      .calc_tag     (calc_tag),
      .cpl_valid    (cpl_valid),
      .cpl_ready    (cpl_ready),
      .cpl_resp     (cpl_resp),
      .cpl_data     (cpl_data),
      .cpl_tag      (cpl_tag),
      .spurious_err (spurious_err)
   );

   always #5 c_clk = ~c_clk;

   task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
      n_checks++;
      if (actual === expected) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
   endtask

   task automatic tick();
      @(posedge c_clk);
      #1;
   endtask

   // Scoreboard monitor: a completion is consumed on the edge following this sample.
   always @(negedge c_clk) begin
      if (!reset && cpl_valid && cpl_ready) begin
         if (exp_q.size() == 0) begin
            check("cpl_unexpected", {31'd0, cpl_valid}, 32'd0);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("cpl_tag", {30'd0, cpl_tag}, {30'd0, e.tag});
            check("cpl_resp", {30'd0, cpl_resp}, {30'd0, e.resp});
            check("cpl_data", cpl_data, e.data);
         end
      end
   end

   task automatic issue(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b,
                        input logic [1:0] tag, input logic [1:0] eresp, input logic [31:0] edata);
      int waited = 0;
      exp_t e;
      op_valid = 1'b1;
      op_cmd   = cmd;
      op_a     = a;
      op_b     = b;
      while (!op_ready && waited < 40) begin
         tick();
         waited++;
      end
      check("op_ready_wait", {31'd0, op_ready}, 32'd1);
      e.resp = eresp;
      e.data = edata;
      e.tag  = tag;
      exp_q.push_back(e);
      tick();
      op_valid = 1'b0;
      op_cmd   = '0;
      op_a     = '0;
      op_b     = '0;
      check("send_a_cmd", {28'd0, req_cmd_out}, {28'd0, cmd});
      check("send_a_data", req_data_out, a);
      check("send_a_tag", {30'd0, req_tag_out}, {30'd0, tag});
   endtask

   task automatic respond(input logic [1:0] tag, input logic [1:0] resp, input logic [31:0] data);
      calc_resp = resp;
      calc_tag  = tag;
      calc_data = data;
      tick();
      calc_resp = '0;
      calc_tag  = '0;
      calc_data = '0;
   endtask

   task automatic wait_drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 60) begin
         tick();
         n++;
      end
      check("drain", exp_q.size(), 32'd0);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      exp_q.delete();
   endtask

   initial begin
      #100000;
      $display("FAIL global_timeout: got no finish, expected finish");
      $fatal(1, "bench time limit reached");
   end

   initial begin
      reset = 1'b1; op_valid = 1'b0; op_cmd = '0; op_a = '0; op_b = '0;
      calc_resp = '0; calc_data = '0; calc_tag = '0; cpl_ready = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      // Reset state
      check("rst_cpl_valid", {31'd0, cpl_valid}, 32'd0);
      check("rst_req_cmd", {28'd0, req_cmd_out}, 32'd0);
      check("rst_spurious", {31'd0, spurious_err}, 32'd0);
      check("rst_op_ready", {31'd0, op_ready}, 32'd1);

      // 1: single add, pin-level two-beat request
      issue(4'd1, 32'h30, 32'h20, 2'd0, 2'd1, 32'h50);
      tick();
      check("send_b_cmd", {28'd0, req_cmd_out}, 32'd0);
      check("send_b_data", req_data_out, 32'h20);
      check("send_b_tag", {30'd0, req_tag_out}, 32'd0);
      tick();
      check("idle_data", req_data_out, 32'd0);
      respond(2'd0, 2'd1, 32'h50);
      wait_drain();

      // 2: four back-to-back ops, reordered responses, stalled consumer
      cpl_ready = 1'b0;
      issue(4'd1, 32'd1, 32'd2, 2'd0, 2'd1, 32'd3);
      issue(4'd2, 32'd10, 32'd3, 2'd1, 2'd1, 32'd7);
      issue(4'd5, 32'd3, 32'd2, 2'd2, 2'd1, 32'd12);
      issue(4'd6, 32'd64, 32'd3, 2'd3, 2'd1, 32'd8);
      tick();
      check("full_op_ready", {31'd0, op_ready}, 32'd0);
      check("full_send_b_data", req_data_out, 32'd3);
      respond(2'd2, 2'd1, 32'd12);
      check("head_not_ready", {31'd0, cpl_valid}, 32'd0);
      respond(2'd0, 2'd1, 32'd3);
      for (int i = 0; i < 5; i++) begin
         check("hold_valid", {31'd0, cpl_valid}, 32'd1);
         check("hold_tag", {30'd0, cpl_tag}, 32'd0);
         check("hold_data", cpl_data, 32'd3);
         check("hold_op_ready", {31'd0, op_ready}, 32'd0);
         tick();
      end
      respond(2'd3, 2'd1, 32'd8);
      respond(2'd1, 2'd1, 32'd7);
      cpl_ready = 1'b1;
      wait_drain();

      // 3: error response masks data; shift ok
      check("pre_spurious", {31'd0, spurious_err}, 32'd0);
      issue(4'd1, 32'hFFFF_FFFF, 32'd1, 2'd0, 2'd2, 32'd0);
      issue(4'd5, 32'd1, 32'd4, 2'd1, 2'd1, 32'h10);
      respond(2'd0, 2'd2, 32'h1234);
      respond(2'd1, 2'd1, 32'h10);
      wait_drain();

      // 4: response for a tag that is not outstanding
      check("pre4_spurious", {31'd0, spurious_err}, 32'd0);
      respond(2'd3, 2'd1, 32'h99);
      check("spurious_set", {31'd0, spurious_err}, 32'd1);
      check("spurious_no_cpl", {31'd0, cpl_valid}, 32'd0);
      tick();
      check("spurious_sticky", {31'd0, spurious_err}, 32'd1);

      // 5: reset while in SEND_B abandons in-flight ops
      issue(4'd1, 32'd5, 32'd6, 2'd0, 2'd1, 32'd11);
      issue(4'd2, 32'd7, 32'd8, 2'd1, 2'd1, 32'hFFFF_FFFF);
      tick();
      check("pre_rst_send_b", req_data_out, 32'd8);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      exp_q.delete();
      check("mid_rst_cmd", {28'd0, req_cmd_out}, 32'd0);
      check("mid_rst_data", req_data_out, 32'd0);
      check("mid_rst_tag", {30'd0, req_tag_out}, 32'd0);
      check("mid_rst_cpl_valid", {31'd0, cpl_valid}, 32'd0);
      check("mid_rst_cpl_data", cpl_data, 32'd0);
      check("mid_rst_spurious", {31'd0, spurious_err}, 32'd0);
      check("mid_rst_op_ready", {31'd0, op_ready}, 32'd1);
      respond(2'd0, 2'd1, 32'd11);
      check("stale_spurious", {31'd0, spurious_err}, 32'd1);
      check("stale_no_cpl", {31'd0, cpl_valid}, 32'd0);
      issue(4'd1, 32'd2, 32'd2, 2'd0, 2'd1, 32'd4);
      respond(2'd0, 2'd1, 32'd4);
      wait_drain();

`ifdef CALC2_ISSUER_TIMEOUT_EN
      // 6: withheld response times out; tag quarantined until the late answer
      do_reset();
      issue(4'd1, 32'd1, 32'd1, 2'd0, 2'd3, 32'd0);
      repeat (4) tick();
      check("to_not_yet", {31'd0, cpl_valid}, 32'd0);
      wait_drain();
      issue(4'd2, 32'd9, 32'd4, 2'd1, 2'd1, 32'd5);
      respond(2'd0, 2'd1, 32'h77);
      check("late_silent", {31'd0, spurious_err}, 32'd0);
      check("late_no_cpl", {31'd0, cpl_valid}, 32'd0);
      respond(2'd1, 2'd1, 32'd5);
      wait_drain();
      issue(4'd1, 32'd3, 32'd3, 2'd0, 2'd1, 32'd6);
      respond(2'd0, 2'd1, 32'd6);
      wait_drain();
      check("to_end_spurious", {31'd0, spurious_err}, 32'd0);
`endif

      repeat (3) tick();
      check("final_queue_empty", exp_q.size(), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
